sb_packet_framer: RTL and testbench

Sideband TX framing stage directly downstream of the sideband data encoder. It captures one 64-bit encoded header and, when the header's opcode carries a payload, the 64-bit encoded data word from the encoder. It then serializes the packet LSB-first onto the sideband TX data line, one bit per clock, and inserts the mandatory 32-UI low gap after every 64-bit serial word. Its output feeds the sideband TX pad logic and the SB clock gating.

---
 rtl/sb_pkg.sv | 17 +
 rtl/sb_piso_shifter.sv | 43 ++++
 rtl/sb_packet_framer.sv | 149 ++++++++++++++
 tb/tb_sb_packet_framer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the sideband TX framing path.
//   sb_framer_state_e : framer control states
//   SB_WORD_W         : serial word width in UI
//   SB_GAP_UI         : idle-low UI inserted after every serial word
package sb_pkg;

    localparam int SB_WORD_W = 64;
    localparam int SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        SHIFT     = 2'd2,
        GAP       = 2'd3
    } sb_framer_state_e;

endpackage

// File: rtl/sb_piso_shifter.sv
// Parallel-load, LSB-first serializer with a bit counter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_word and restart the bit counter (wins over shift)
//   i_word       : parallel word to serialize
//   i_shift_en   : advance one bit
//   o_bit        : current serial bit (word LSB first)
//   o_cnt_done   : current bit is the last bit of the word
module sb_piso_shifter
    import sb_pkg::*;
#(
    parameter int WORD_W = SB_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift_en,
    output logic              o_bit,
    output logic              o_cnt_done
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] sreg_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (i_load) begin
            sreg_q <= i_word;
            cnt_q  <= '0;
        end else if (i_shift_en) begin
            sreg_q <= {1'b0, sreg_q[WORD_W-1:1]};
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    assign o_bit      = sreg_q[0];
    assign o_cnt_done = (cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/sb_packet_framer.sv
// Sideband TX packet framer: captures an encoded header (and optional data
// word), serializes each word LSB-first one bit per clock, and inserts a
// low gap after every word.
//   i_clk, i_rst        : UI clock, asynchronous active-high reset
//   i_hdr_valid, i_hdr  : header pulse and word (accepted only when o_ready)
//   i_has_data          : packet carries a data word (sampled with header)
//   i_d_valid, i_data_encoded : encoder data word
//   o_ready             : idle, can accept a header
//   o_txdata_sb         : serial TX bit
//   o_tx_active         : high on every UI carrying a packet bit
//   o_pkt_done          : pulse on the last gap UI of a packet
//   o_err_data_missing  : pulse when the data word never arrived
module sb_packet_framer
    import sb_pkg::*;
#(
    parameter int WORD_W       = SB_WORD_W,
    parameter int GAP_UI       = SB_GAP_UI,
    parameter int DATA_TIMEOUT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hdr_valid,
    input  logic [WORD_W-1:0] i_hdr,
    input  logic              i_has_data,
    input  logic              i_d_valid,
    input  logic [WORD_W-1:0] i_data_encoded,
    output logic              o_ready,
    output logic              o_txdata_sb,
    output logic              o_tx_active,
    output logic              o_pkt_done,
    output logic              o_err_data_missing
);

    localparam int GAP_W  = $clog2(GAP_UI);
    localparam int WAIT_W = $clog2(DATA_TIMEOUT + 1);

    sb_framer_state_e  state_q, state_d;
    logic [WORD_W-1:0] data_q;
    logic              pend_q;      // data word still to be sent after the header
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              err_q;

    logic hdr_load, data_load, data_capture, timeout;
    logic gap_last, wait_last;
    logic ser_bit, bit_last;

    assign gap_last  = (gap_cnt_q == GAP_W'(GAP_UI - 1));
    assign wait_last = (wait_cnt_q == WAIT_W'(DATA_TIMEOUT - 1));

    // The header is loaded straight into the shifter at acceptance, so the
    // shifter itself holds it through WAIT_DATA; the data word waits in data_q.
    sb_piso_shifter #(
        .WORD_W (WORD_W)
    ) u_piso (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (hdr_load | data_load),
        .i_word     (data_load ? data_q : i_hdr),
        .i_shift_en (state_q == SHIFT),
        .o_bit      (ser_bit),
        .o_cnt_done (bit_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_load     = 1'b0;
        data_load    = 1'b0;
        data_capture = 1'b0;
        timeout      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_hdr_valid) begin
                    hdr_load = 1'b1;
                    if (!i_has_data) begin
                        state_d = SHIFT;
                    end else if (i_d_valid) begin
                        data_capture = 1'b1;
                        state_d      = SHIFT;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (i_d_valid) begin
                    data_capture = 1'b1;
                    state_d      = SHIFT;
                end else if (wait_last) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_last) begin
                    if (pend_q) begin
                        data_load = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q     <= '0;
            pend_q     <= 1'b0;
            gap_cnt_q  <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (data_capture) begin
                data_q <= i_data_encoded;
            end
            if (hdr_load) begin
                pend_q <= i_has_data;
            end else if (data_load || timeout) begin
                pend_q <= 1'b0;
            end
            gap_cnt_q  <= (state_q == GAP) ? gap_cnt_q + GAP_W'(1) : '0;
            wait_cnt_q <= (state_q == WAIT_DATA) ? wait_cnt_q + WAIT_W'(1) : '0;
            err_q      <= timeout;
        end
    end

    assign o_ready            = (state_q == IDLE);
    assign o_tx_active        = (state_q == SHIFT);
    assign o_txdata_sb        = (state_q == SHIFT) && ser_bit;
    assign o_pkt_done         = (state_q == GAP) && gap_last && !pend_q;
    assign o_err_data_missing = err_q;

endmodule

// File: tb/tb_sb_packet_framer.sv
module tb_sb_packet_framer;

    localparam int W    = 64;
    localparam int GAPN = 32;
    localparam int TO   = 4;
    localparam int SLOT = W + GAPN;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_hdr_valid = 1'b0;
    logic [W-1:0]  i_hdr = '0;
    logic          i_has_data = 1'b0;
    logic          i_d_valid = 1'b0;
    logic [W-1:0]  i_data_encoded = '0;
    logic          o_ready, o_txdata_sb, o_tx_active, o_pkt_done, o_err_data_missing;

    int n_cmp = 0;
    int n_bad = 0;

    sb_packet_framer #(
        .WORD_W       (W),
        .GAP_UI       (GAPN),
        .DATA_TIMEOUT (TO)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_hdr_valid        (i_hdr_valid),
        .i_hdr              (i_hdr),
        .i_has_data         (i_has_data),
        .i_d_valid          (i_d_valid),
        .i_data_encoded     (i_data_encoded),
        .o_ready            (o_ready),
        .o_txdata_sb        (o_txdata_sb),
        .o_tx_active        (o_tx_active),
        .o_pkt_done         (o_pkt_done),
        .o_err_data_missing (o_err_data_missing)
    );

    always #5 i_clk = ~i_clk;

    // outputs packed as {txdata, active, done, err, ready}
    function automatic logic [4:0] outs();
        return {o_txdata_sb, o_tx_active, o_pkt_done, o_err_data_missing, o_ready};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Expected outputs c cycles after header acceptance, derived from the
    // packet layout: optional wait of d cycles, then words of W bits each
    // followed by GAPN low UIs.
    function automatic logic [4:0] model(input int c, input logic [W-1:0] hdr,
                                         input logic hd, input logic [W-1:0] data, input int d);
        int s, words, o, p;
        logic [W-1:0] word;
        if (hd && d > TO) begin
            if (c == TO + 1) return 5'b00011;
            return (c > TO + 1) ? 5'b00001 : 5'b00000;
        end
        s     = hd ? d : 0;
        words = hd ? 2 : 1;
        if (c <= s) return 5'b00000;
        o = c - s - 1;
        if (o >= SLOT * words) return 5'b00001;
        p    = o % SLOT;
        word = (o < SLOT) ? hdr : data;
        if (p < W) return {word[p], 1'b1, 3'b000};
        return {2'b00, (o == SLOT * words - 1), 2'b00};
    endfunction

    // Start a packet in the current (idle) cycle and check every cycle until
    // one cycle after it is over. d = data arrival cycle; d > TO never arrives.
    task automatic run_pkt(input string name, input logic [W-1:0] hdr, input logic hd,
                           input logic [W-1:0] data, input int d, input bit noise,
                           output int done_at, output int err_at);
        bit tmo;
        int s, last;
        logic [4:0] a, e;
        tmo  = hd && (d > TO);
        s    = hd ? d : 0;
        last = tmo ? TO + 1 : s + SLOT * (hd ? 2 : 1);
        done_at = -1;
        err_at  = -1;
        check({name, " ready_at_T"}, 64'(o_ready), 64'd1);
        i_hdr_valid    = 1'b1;
        i_hdr          = hdr;
        i_has_data     = hd;
        i_d_valid      = hd && (d == 0);
        i_data_encoded = (hd && d == 0) ? data : rnd64();
        for (int c = 1; c <= last + 1; c++) begin
            step();
            a = outs();
            e = model(c, hdr, hd, data, d);
            if (o_pkt_done) done_at = c;
            if (o_err_data_missing) err_at = c;
            if (a !== e) check($sformatf("%s c%0d", name, c), 64'(a), 64'(e));
            else n_cmp++;
            i_hdr_valid    = 1'b0;
            i_hdr          = rnd64();
            i_has_data     = 1'($urandom());
            i_d_valid      = 1'b0;
            i_data_encoded = rnd64();
            if (!tmo && hd && c == d) begin
                i_d_valid      = 1'b1;
                i_data_encoded = data;
            end else if (tmo && c == TO + 1) begin
                i_d_valid = 1'b1;  // late data lands in IDLE without a header
            end else if (noise) begin
                if (c > s && !tmo) i_d_valid = 1'($urandom());
                if (c < last) i_hdr_valid = 1'($urandom());
            end
        end
        i_hdr_valid = 1'b0;
        i_d_valid   = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] hdr;
        logic         has_data;
        logic [W-1:0] data;
        int           delay;
        int           exp_done;
        int           exp_err;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int done_at, err_at;

        vecs[0] = '{64'hA5A5_0000_0000_0001, 1'b0, 64'h0,                   0,  96, -1};
        vecs[1] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0000_0000_0000_07FF, 0, 192, -1};
        vecs[2] = '{64'hFFFF_0000_FFFF_0000, 1'b1, 64'h8000_0000_0000_0001, 2, 194, -1};
        vecs[3] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h1111_2222_3333_4444, 9,  -1,  5};
        vecs[4] = '{64'h0123_4567_89AB_CDEF, 1'b1, 64'hF0F0_0F0F_AAAA_5555, 4, 196, -1};

        #2 i_rst = 1'b1;
        #1 check("reset_outputs", 64'(outs()), 64'h01);
        step();
        i_rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            run_pkt($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].has_data, vecs[i].data,
                    vecs[i].delay, 1'b0, done_at, err_at);
            check($sformatf("vec%0d done_cycle", i), 64'(done_at), 64'(vecs[i].exp_done));
            check($sformatf("vec%0d err_cycle", i), 64'(err_at), 64'(vecs[i].exp_err));
        end

        // encoder valid with no header while idle must not start anything
        for (int c = 0; c < 6; c++) begin
            i_d_valid      = 1'b1;
            i_data_encoded = rnd64();
            step();
            check($sformatf("idle_dvalid c%0d", c), 64'(outs()), 64'h01);
        end
        i_d_valid = 1'b0;
        run_pkt("after_idle_dvalid", 64'h8000_0000_0000_0003, 1'b0, 64'h0, 0, 1'b1, done_at, err_at);
        check("after_idle_dvalid done", 64'(done_at), 64'd96);

        // reset in the middle of a header word
        i_hdr_valid = 1'b1;
        i_hdr       = 64'h0000_0000_2000_0000;
        i_has_data  = 1'b1;
        i_d_valid   = 1'b1;
        i_data_encoded = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        i_hdr_valid = 1'b0;
        i_d_valid   = 1'b0;
        for (int c = 2; c <= 30; c++) step();
        check("pre_reset active_bit", 64'({o_txdata_sb, o_tx_active}), 64'b11);
        i_rst = 1'b1;
        #1 check("async_reset outputs", 64'(outs()), 64'h01);
        step();
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("post_reset idle c%0d", c), 64'(outs()), 64'h01);
        end
        run_pkt("post_reset", 64'hC3C3_5A5A_0F0F_F0F1, 1'b0, 64'h0, 0, 1'b0, done_at, err_at);
        check("post_reset done", 64'(done_at), 64'd96);

        // randomized packets with ignored-input noise
        for (int r = 0; r < 12; r++) begin
            logic hd;
            int d;
            hd = 1'($urandom());
            d  = int'($urandom_range(0, 6));
            run_pkt($sformatf("rnd%0d", r), rnd64(), hd, rnd64(), d, 1'b1, done_at, err_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
